sel_encode_sb: RTL and testbench
================================

Name: sel_encode_sb

Overview:
- Parametrised select-and-encode unit with a latched IR and a per-register write-pending scoreboard, for the pipelined datapath.
- Decodes the Ra/Rb/Rc IR fields into one-hot register-file in/out enables and produces the sign-extended C constant.
- Tracks registers with outstanding writes and raises a hazard/stall toward the control unit.

Parameters:
- NREGS, 16, number of general registers (power of two)
- RIDX_W, 4, register index width, equal to log2(NREGS)
- DATA_W, 32, bus width
- CONST_W, 19, width of the C immediate, IR[CONST_W-1:0]
- RA_LSB, 23, LSB of the Ra field
- RB_LSB, 19, LSB of the Rb field
- RC_LSB, 15, LSB of the Rc field
- STALL_MAX, 15, saturating stall count that raises stall_timeout

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- ir_load  in  1  capture ir_in into the internal IR
- ir_in  in  DATA_W  instruction word
- gra, grb, grc  in  1 each  field select, priority gra > grb > grc
- rin, rout, baout  in  1 each  register in / out / base-address-out strobes
- reg_in  out  NREGS  one-hot write enables
- reg_out  out  NREGS  one-hot read enables
- bus_zero  out  1  drive zero onto the bus (R0 base-address case)
- c_sign  out  DATA_W  sign-extended C field
- issue_valid  in  1  instruction issuing; its Ra becomes pending
- issue_ready  out  1  issue accepted this cycle
- wb_valid  in  1  writeback completing
- wb_idx  in  RIDX_W  register being written back
- check_en  in  1  enable the hazard check on Ra/Rb/Rc
- hazard  out  1  a checked source or destination is pending
- pending  out  NREGS  scoreboard bit vector
- stall_cnt  out  RIDX_W+1  consecutive hazard cycles, saturating
- stall_timeout  out  1  stall_cnt == STALL_MAX

Behaviour:
- Reset value of all registered state is zero: ir_q, last_sel, pending, stall_cnt. Therefore hazard=0, issue_ready=1, c_sign=0, stall_timeout=0.
- IR latch: on ir_load, ir_q <= ir_in. All decode uses ir_q, so there is one cycle of latency from ir_in.
- Field extract:
  - ra = ir_q[RA_LSB+RIDX_W-1:RA_LSB]; rb and rc are extracted the same way.
  - Fields are exactly RIDX_W bits; no truncation or overlap logic.
- Select:
  - sel = ra if gra, else rb if grb, else rc if grc, else last_sel.
  - last_sel <= sel whenever any gr is high.
- Encode:
  - onehot = 1 << sel.
  - reg_in = onehot if rin, else 0.
  - reg_out = onehot if (rout | baout), else 0.
  - R0 base-address case: when baout=1 and sel=0, reg_out=0 and bus_zero=1. Otherwise bus_zero=0.
  - Encode paths are combinational.
- c_sign: {(DATA_W-CONST_W) copies of ir_q[CONST_W-1], ir_q[CONST_W-1:0]}.
- Scoreboard:
  - Set: issue_valid & issue_ready sets pending[ra].
  - Clear: wb_valid clears pending[wb_idx].
  - Set and clear of the same index in one cycle: set wins.
  - Clear of a non-pending register: no effect.
- Hazard: hazard = check_en & (pending[ra] | pending[rb] | pending[rc]). The Ra check covers WAW.
- issue_ready = ~hazard. issue_valid with hazard=1 is ignored; no state change.
- Stall counter:
  - Increments while hazard=1, saturating at STALL_MAX.
  - Cleared to 0 on the first cycle with hazard=0.
  - stall_timeout = (stall_cnt == STALL_MAX).
- Reset asserted mid-stall clears pending and stall_cnt in the same edge. Outputs are clean the next cycle.

Optional Feature:
- Macro: SB_BYPASS_EN.
- Defined: a wb_valid in the current cycle masks pending[wb_idx] in the hazard equation, so writeback-to-read forwarding avoids a one-cycle stall.
- Undefined: hazard uses registered pending only; the clear takes effect the next cycle.

Decomposition:
- Shared package sel_encode_pkg holds:
  - RIDX_W/NREGS defaults and the field-LSB constants
  - a function onehot(idx)
  - a function sext(value, width)
- One natural sub-module: sb_scoreboard, containing the pending vector, set/clear priority, hazard and stall counter.
- The select/encode logic stays in the top level.

Test Plan:
- Decode: reset; load ir_in=0x0128_8000 (ra=2, rb=5, rc=1); gra+rin -> reg_in=0x0004; grb+rout -> reg_out=0x0020; grc+rout -> reg_out=0x0002.
- Base-address R0: ra=0, gra+baout -> reg_out=0, bus_zero=1; ra=3, gra+baout -> reg_out=0x0008, bus_zero=0.
- Sign-extension: IR[18:0]=0x40000 -> c_sign=0xFFFC_0000; IR[18:0]=0x3FFFF -> c_sign=0x0003_FFFF.
- Scoreboard RAW:
  - Issue with ra=4 -> pending=0x0010.
  - Next instruction has rb=4, check_en=1 -> hazard=1, issue_ready=0.
  - wb_valid with wb_idx=4 -> hazard=0 next cycle, or the same cycle with SB_BYPASS_EN.
- Simultaneous events:
  - Issue ra=7 and wb_idx=7 in the same cycle -> pending[7]=1.
  - Issue while hazard=1 -> pending unchanged.
- Stall saturation and reset:
  - Hold the hazard 20 cycles -> stall_cnt=15 and stall_timeout=1 from cycle 15 onward.
  - Assert reset mid-stall -> pending=0, stall_cnt=0, hazard=0 on the next cycle.

Source files
------------

// File: rtl/sel_encode_pkg.sv
// Shared constants and helpers for the select/encode unit and its scoreboard.
package sel_encode_pkg;

  localparam int NREGS_DEF     = 16;
  localparam int RIDX_W_DEF    = 4;
  localparam int DATA_W_DEF    = 32;
  localparam int CONST_W_DEF   = 19;
  localparam int RA_LSB_DEF    = 23;
  localparam int RB_LSB_DEF    = 19;
  localparam int RC_LSB_DEF    = 15;
  localparam int STALL_MAX_DEF = 15;

  // Helpers work at a fixed maximum width; callers size-cast the result down.
  localparam int MAX_REGS = 64;
  localparam int MAX_W    = 64;

  function automatic logic [MAX_REGS-1:0] onehot(input int unsigned idx);
    return MAX_REGS'(1) << idx;
  endfunction

  function automatic logic [MAX_W-1:0] sext(input logic [MAX_W-1:0] value,
                                            input int unsigned width);
    logic [MAX_W-1:0] upper;
    upper = {MAX_W{1'b1}} << width;
    if (((value >> (width - 1)) & MAX_W'(1)) != '0) return value | upper;
    return value & ~upper;
  endfunction

endpackage

// File: rtl/sel_encode_sb_if.sv
// Bus bundle between the control unit (master) and the select/encode unit (slave).
interface sel_encode_sb_if #(
  parameter int NREGS  = 16,
  parameter int RIDX_W = 4,
  parameter int DATA_W = 32
);

  logic              ir_load;
  logic [DATA_W-1:0] ir_in;
  logic              gra, grb, grc;
  logic              rin, rout, baout;
  logic [NREGS-1:0]  reg_in;
  logic [NREGS-1:0]  reg_out;
  logic              bus_zero;
  logic [DATA_W-1:0] c_sign;
  logic              issue_valid;
  logic              issue_ready;
  logic              wb_valid;
  logic [RIDX_W-1:0] wb_idx;
  logic              check_en;
  logic              hazard;
  logic [NREGS-1:0]  pending;
  logic [RIDX_W:0]   stall_cnt;
  logic              stall_timeout;

  modport master (
    output ir_load, ir_in, gra, grb, grc, rin, rout, baout,
           issue_valid, wb_valid, wb_idx, check_en,
    input  reg_in, reg_out, bus_zero, c_sign, issue_ready,
           hazard, pending, stall_cnt, stall_timeout
  );

  modport slave (
    input  ir_load, ir_in, gra, grb, grc, rin, rout, baout,
           issue_valid, wb_valid, wb_idx, check_en,
    output reg_in, reg_out, bus_zero, c_sign, issue_ready,
           hazard, pending, stall_cnt, stall_timeout
  );

endinterface

// File: rtl/sb_scoreboard.sv
// Write-pending scoreboard with hazard detect and saturating stall counter.
// SB_BYPASS_EN: a same-cycle writeback masks its own pending bit in the hazard check.
module sb_scoreboard
  import sel_encode_pkg::*;
#(
  parameter int NREGS     = NREGS_DEF,
  parameter int RIDX_W    = RIDX_W_DEF,
  parameter int STALL_MAX = STALL_MAX_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [RIDX_W-1:0] ra,
  input  logic [RIDX_W-1:0] rb,
  input  logic [RIDX_W-1:0] rc,
  input  logic              check_en,
  input  logic              issue_valid,
  input  logic              wb_valid,
  input  logic [RIDX_W-1:0] wb_idx,
  output logic              hazard,
  output logic              issue_ready,
  output logic [NREGS-1:0]  pending,
  output logic [RIDX_W:0]   stall_cnt,
  output logic              stall_timeout
);

  localparam logic [RIDX_W:0] STALL_LIMIT = (RIDX_W+1)'(STALL_MAX);
  localparam logic [RIDX_W:0] STALL_ONE   = (RIDX_W+1)'(1);

  logic [NREGS-1:0] pending_reg, pending_next;
  logic [NREGS-1:0] wb_mask, set_mask, hazard_view;
  logic [RIDX_W:0]  stall_cnt_reg, stall_cnt_next;

  assign wb_mask  = wb_valid ? NREGS'(onehot(32'(wb_idx))) : '0;
  assign set_mask = (issue_valid && issue_ready) ? NREGS'(onehot(32'(ra))) : '0;

`ifdef SB_BYPASS_EN
  assign hazard_view = pending_reg & ~wb_mask;
`else
  assign hazard_view = pending_reg;
`endif

  // Checking Ra as well as Rb/Rc catches write-after-write on the destination.
  assign hazard      = check_en && (hazard_view[ra] || hazard_view[rb] || hazard_view[rc]);
  assign issue_ready = !hazard;

  // Set beats clear when both target the same register.
  for (genvar gi = 0; gi < NREGS; gi++) begin : g_pend
    assign pending_next[gi] = set_mask[gi] | (pending_reg[gi] & ~wb_mask[gi]);
  end

  always_comb begin
    stall_cnt_next = '0;
    if (hazard)
      stall_cnt_next = (stall_cnt_reg >= STALL_LIMIT) ? STALL_LIMIT : stall_cnt_reg + STALL_ONE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pending_reg   <= '0;
      stall_cnt_reg <= '0;
    end else begin
      pending_reg   <= pending_next;
      stall_cnt_reg <= stall_cnt_next;
    end
  end

  assign pending       = pending_reg;
  assign stall_cnt     = stall_cnt_reg;
  assign stall_timeout = (stall_cnt_reg == STALL_LIMIT);

endmodule

// File: rtl/sel_encode_sb.sv
// Select-and-encode unit: latched IR, one-hot register enables, sign-extended C constant.
// Hazard tracking lives in sb_scoreboard (see SB_BYPASS_EN there).
module sel_encode_sb
  import sel_encode_pkg::*;
#(
  parameter int NREGS     = NREGS_DEF,
  parameter int RIDX_W    = RIDX_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int CONST_W   = CONST_W_DEF,
  parameter int RA_LSB    = RA_LSB_DEF,
  parameter int RB_LSB    = RB_LSB_DEF,
  parameter int RC_LSB    = RC_LSB_DEF,
  parameter int STALL_MAX = STALL_MAX_DEF
) (
  input logic            clock,
  input logic            reset,
  sel_encode_sb_if.slave sb
);

  logic [DATA_W-1:0] ir_q_reg;
  logic [RIDX_W-1:0] last_sel_reg;
  logic [RIDX_W-1:0] ra, rb, rc, sel;
  logic [NREGS-1:0]  onehot_sel;
  logic              base_r0;
  logic              unused_ir;

  assign ra = ir_q_reg[RA_LSB +: RIDX_W];
  assign rb = ir_q_reg[RB_LSB +: RIDX_W];
  assign rc = ir_q_reg[RC_LSB +: RIDX_W];

  // Opcode bits above the fields are decoded by the control unit, not here.
  assign unused_ir = ^ir_q_reg;

  always_comb begin
    sel = last_sel_reg;
    if (sb.gra)      sel = ra;
    else if (sb.grb) sel = rb;
    else if (sb.grc) sel = rc;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ir_q_reg     <= '0;
      last_sel_reg <= '0;
    end else begin
      if (sb.ir_load) ir_q_reg <= sb.ir_in;
      if (sb.gra || sb.grb || sb.grc) last_sel_reg <= sel;
    end
  end

  assign onehot_sel = NREGS'(onehot(32'(sel)));

  // BAout on R0 reads as constant zero instead of register 0.
  assign base_r0     = sb.baout && (sel == '0);
  assign sb.reg_in   = sb.rin ? onehot_sel : '0;
  assign sb.reg_out  = ((sb.rout || sb.baout) && !base_r0) ? onehot_sel : '0;
  assign sb.bus_zero = base_r0;
  assign sb.c_sign   = DATA_W'(sext(MAX_W'(ir_q_reg[CONST_W-1:0]), CONST_W));

  sb_scoreboard #(
    .NREGS     (NREGS),
    .RIDX_W    (RIDX_W),
    .STALL_MAX (STALL_MAX)
  ) u_sb (
    .clock         (clock),
    .reset         (reset),
    .ra            (ra),
    .rb            (rb),
    .rc            (rc),
    .check_en      (sb.check_en),
    .issue_valid   (sb.issue_valid),
    .wb_valid      (sb.wb_valid),
    .wb_idx        (sb.wb_idx),
    .hazard        (sb.hazard),
    .issue_ready   (sb.issue_ready),
    .pending       (sb.pending),
    .stall_cnt     (sb.stall_cnt),
    .stall_timeout (sb.stall_timeout)
  );

endmodule

// File: tb/tb_sel_encode_sb.sv
// Directed bench for sel_encode_sb: decode, base-address, sign-extension, scoreboard, stall.
module tb_sel_encode_sb;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clock = ~clock;

  sel_encode_sb_if #(.NREGS(16), .RIDX_W(4), .DATA_W(32)) sb_if ();

  sel_encode_sb dut (
    .clock (clock),
    .reset (reset),
    .sb    (sb_if)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    sb_if.ir_load     = 1'b0;
    sb_if.ir_in       = '0;
    sb_if.gra         = 1'b0;
    sb_if.grb         = 1'b0;
    sb_if.grc         = 1'b0;
    sb_if.rin         = 1'b0;
    sb_if.rout        = 1'b0;
    sb_if.baout       = 1'b0;
    sb_if.issue_valid = 1'b0;
    sb_if.wb_valid    = 1'b0;
    sb_if.wb_idx      = '0;
    sb_if.check_en    = 1'b0;
  endtask

  task automatic load_ir(input logic [31:0] value);
    sb_if.ir_in   = value;
    sb_if.ir_load = 1'b1;
    tick();
    sb_if.ir_load = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    sb_if.check_en = 1'b1;
    settle();
    n_checks++;
    if (sb_if.pending !== 16'h0000) begin n_fail++; $display("FAIL reset_pending: got %h expected 0000", sb_if.pending); end
    else $display("ok reset_pending %h", sb_if.pending);
    n_checks++;
    if (sb_if.stall_cnt !== 5'd0) begin n_fail++; $display("FAIL reset_stall_cnt: got %0d expected 0", sb_if.stall_cnt); end
    else $display("ok reset_stall_cnt %0d", sb_if.stall_cnt);
    n_checks++;
    if (sb_if.hazard !== 1'b0 || sb_if.issue_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_hazard: got hazard=%b ready=%b expected hazard=0 ready=1", sb_if.hazard, sb_if.issue_ready);
    end else $display("ok reset_hazard hazard=%b ready=%b", sb_if.hazard, sb_if.issue_ready);
    n_checks++;
    if (sb_if.c_sign !== 32'h0 || sb_if.stall_timeout !== 1'b0) begin
      n_fail++; $display("FAIL reset_csign_timeout: got c_sign=%h timeout=%b expected 0/0", sb_if.c_sign, sb_if.stall_timeout);
    end else $display("ok reset_csign_timeout c_sign=%h timeout=%b", sb_if.c_sign, sb_if.stall_timeout);
    sb_if.check_en = 1'b0;
  endtask

  task automatic test_decode();
    load_ir(32'h0128_8000);
    sb_if.gra = 1'b1; sb_if.rin = 1'b1;
    settle();
    n_checks++;
    if (sb_if.reg_in !== 16'h0004) begin n_fail++; $display("FAIL decode_gra_rin: got %h expected 0004", sb_if.reg_in); end
    else $display("ok decode_gra_rin %h", sb_if.reg_in);
    n_checks++;
    if (sb_if.reg_out !== 16'h0000) begin n_fail++; $display("FAIL decode_no_rout: got %h expected 0000", sb_if.reg_out); end
    else $display("ok decode_no_rout %h", sb_if.reg_out);
    tick();
    sb_if.gra = 1'b0; sb_if.rin = 1'b0; sb_if.grb = 1'b1; sb_if.rout = 1'b1;
    settle();
    n_checks++;
    if (sb_if.reg_out !== 16'h0020) begin n_fail++; $display("FAIL decode_grb_rout: got %h expected 0020", sb_if.reg_out); end
    else $display("ok decode_grb_rout %h", sb_if.reg_out);
    tick();
    sb_if.grb = 1'b0; sb_if.grc = 1'b1;
    settle();
    n_checks++;
    if (sb_if.reg_out !== 16'h0002) begin n_fail++; $display("FAIL decode_grc_rout: got %h expected 0002", sb_if.reg_out); end
    else $display("ok decode_grc_rout %h", sb_if.reg_out);
    tick();
    sb_if.grc = 1'b0;
    settle();
    n_checks++;
    if (sb_if.reg_out !== 16'h0002) begin n_fail++; $display("FAIL decode_last_sel: got %h expected 0002", sb_if.reg_out); end
    else $display("ok decode_last_sel %h", sb_if.reg_out);
    n_checks++;
    if (sb_if.c_sign !== 32'h0000_8000) begin n_fail++; $display("FAIL decode_csign: got %h expected 00008000", sb_if.c_sign); end
    else $display("ok decode_csign %h", sb_if.c_sign);
    idle_inputs();
  endtask

  task automatic test_base_addr();
    load_ir(32'h0000_0000);
    sb_if.gra = 1'b1; sb_if.baout = 1'b1;
    settle();
    n_checks++;
    if (sb_if.reg_out !== 16'h0000 || sb_if.bus_zero !== 1'b1) begin
      n_fail++; $display("FAIL base_r0: got reg_out=%h bus_zero=%b expected 0000/1", sb_if.reg_out, sb_if.bus_zero);
    end else $display("ok base_r0 reg_out=%h bus_zero=%b", sb_if.reg_out, sb_if.bus_zero);
    sb_if.gra = 1'b0; sb_if.baout = 1'b0;
    load_ir(32'h0180_0000);
    sb_if.gra = 1'b1; sb_if.baout = 1'b1;
    settle();
    n_checks++;
    if (sb_if.reg_out !== 16'h0008 || sb_if.bus_zero !== 1'b0) begin
      n_fail++; $display("FAIL base_r3: got reg_out=%h bus_zero=%b expected 0008/0", sb_if.reg_out, sb_if.bus_zero);
    end else $display("ok base_r3 reg_out=%h bus_zero=%b", sb_if.reg_out, sb_if.bus_zero);
    idle_inputs();
  endtask

  task automatic test_sign_ext();
    load_ir(32'h0004_0000);
    settle();
    n_checks++;
    if (sb_if.c_sign !== 32'hFFFC_0000) begin n_fail++; $display("FAIL sext_neg: got %h expected fffc0000", sb_if.c_sign); end
    else $display("ok sext_neg %h", sb_if.c_sign);
    load_ir(32'h0003_FFFF);
    settle();
    n_checks++;
    if (sb_if.c_sign !== 32'h0003_FFFF) begin n_fail++; $display("FAIL sext_pos: got %h expected 0003ffff", sb_if.c_sign); end
    else $display("ok sext_pos %h", sb_if.c_sign);
  endtask

  task automatic test_scoreboard_raw();
    logic exp_hz_wb;
    load_ir(32'h0200_0000);
    sb_if.issue_valid = 1'b1; sb_if.check_en = 1'b1;
    settle();
    n_checks++;
    if (sb_if.issue_ready !== 1'b1) begin n_fail++; $display("FAIL raw_issue_ready: got %b expected 1", sb_if.issue_ready); end
    else $display("ok raw_issue_ready %b", sb_if.issue_ready);
    tick();
    sb_if.issue_valid = 1'b0;
    n_checks++;
    if (sb_if.pending !== 16'h0010) begin n_fail++; $display("FAIL raw_pending_set: got %h expected 0010", sb_if.pending); end
    else $display("ok raw_pending_set %h", sb_if.pending);
    load_ir(32'h0020_0000);
    settle();
    n_checks++;
    if (sb_if.hazard !== 1'b1 || sb_if.issue_ready !== 1'b0) begin
      n_fail++; $display("FAIL raw_hazard: got hazard=%b ready=%b expected 1/0", sb_if.hazard, sb_if.issue_ready);
    end else $display("ok raw_hazard hazard=%b ready=%b", sb_if.hazard, sb_if.issue_ready);
    sb_if.wb_valid = 1'b1; sb_if.wb_idx = 4'd4;
    settle();
`ifdef SB_BYPASS_EN
    exp_hz_wb = 1'b0;
`else
    exp_hz_wb = 1'b1;
`endif
    n_checks++;
    if (sb_if.hazard !== exp_hz_wb) begin n_fail++; $display("FAIL raw_wb_same_cycle: got %b expected %b", sb_if.hazard, exp_hz_wb); end
    else $display("ok raw_wb_same_cycle hazard=%b", sb_if.hazard);
    tick();
    sb_if.wb_valid = 1'b0;
    settle();
    n_checks++;
    if (sb_if.hazard !== 1'b0 || sb_if.pending !== 16'h0000) begin
      n_fail++; $display("FAIL raw_wb_next: got hazard=%b pending=%h expected 0/0000", sb_if.hazard, sb_if.pending);
    end else $display("ok raw_wb_next hazard=%b pending=%h", sb_if.hazard, sb_if.pending);
    idle_inputs();
  endtask

  task automatic test_simultaneous();
    load_ir(32'h0380_0000);
    sb_if.issue_valid = 1'b1; sb_if.wb_valid = 1'b1; sb_if.wb_idx = 4'd7;
    tick();
    sb_if.issue_valid = 1'b0; sb_if.wb_valid = 1'b0;
    n_checks++;
    if (sb_if.pending !== 16'h0080) begin n_fail++; $display("FAIL sim_set_wins: got %h expected 0080", sb_if.pending); end
    else $display("ok sim_set_wins %h", sb_if.pending);
    load_ir(32'h0138_0000);
    sb_if.check_en = 1'b1; sb_if.issue_valid = 1'b1;
    settle();
    n_checks++;
    if (sb_if.hazard !== 1'b1 || sb_if.issue_ready !== 1'b0) begin
      n_fail++; $display("FAIL sim_hazard_rb: got hazard=%b ready=%b expected 1/0", sb_if.hazard, sb_if.issue_ready);
    end else $display("ok sim_hazard_rb hazard=%b ready=%b", sb_if.hazard, sb_if.issue_ready);
    tick();
    sb_if.issue_valid = 1'b0; sb_if.check_en = 1'b0;
    n_checks++;
    if (sb_if.pending !== 16'h0080) begin n_fail++; $display("FAIL sim_issue_blocked: got %h expected 0080", sb_if.pending); end
    else $display("ok sim_issue_blocked %h", sb_if.pending);
    sb_if.wb_valid = 1'b1; sb_if.wb_idx = 4'd3;
    tick();
    n_checks++;
    if (sb_if.pending !== 16'h0080) begin n_fail++; $display("FAIL sim_clear_idle: got %h expected 0080", sb_if.pending); end
    else $display("ok sim_clear_idle %h", sb_if.pending);
    sb_if.wb_idx = 4'd7;
    tick();
    sb_if.wb_valid = 1'b0;
    n_checks++;
    if (sb_if.pending !== 16'h0000) begin n_fail++; $display("FAIL sim_clear_7: got %h expected 0000", sb_if.pending); end
    else $display("ok sim_clear_7 %h", sb_if.pending);
    idle_inputs();
  endtask

  task automatic test_stall_reset();
    logic [4:0] exp_cnt;
    logic       exp_to;
    load_ir(32'h0280_0000);
    sb_if.issue_valid = 1'b1;
    tick();
    sb_if.issue_valid = 1'b0;
    n_checks++;
    if (sb_if.pending !== 16'h0020 || sb_if.stall_cnt !== 5'd0) begin
      n_fail++; $display("FAIL stall_setup: got pending=%h cnt=%0d expected 0020/0", sb_if.pending, sb_if.stall_cnt);
    end else $display("ok stall_setup pending=%h cnt=%0d", sb_if.pending, sb_if.stall_cnt);
    sb_if.check_en = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      exp_cnt = (i >= 15) ? 5'd15 : 5'(i);
      exp_to  = (i >= 15);
      n_checks++;
      if (sb_if.stall_cnt !== exp_cnt || sb_if.stall_timeout !== exp_to) begin
        n_fail++; $display("FAIL stall_cycle_%0d: got cnt=%0d timeout=%b expected %0d/%b", i, sb_if.stall_cnt, sb_if.stall_timeout, exp_cnt, exp_to);
      end else $display("ok stall_cycle_%0d cnt=%0d timeout=%b", i, sb_if.stall_cnt, sb_if.stall_timeout);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    settle();
    n_checks++;
    if (sb_if.pending !== 16'h0000 || sb_if.stall_cnt !== 5'd0 || sb_if.hazard !== 1'b0 || sb_if.stall_timeout !== 1'b0) begin
      n_fail++; $display("FAIL stall_reset: got pending=%h cnt=%0d hazard=%b timeout=%b expected 0000/0/0/0",
                         sb_if.pending, sb_if.stall_cnt, sb_if.hazard, sb_if.stall_timeout);
    end else $display("ok stall_reset pending=%h cnt=%0d hazard=%b", sb_if.pending, sb_if.stall_cnt, sb_if.hazard);
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_decode();
    test_base_addr();
    test_sign_ext();
    test_scoreboard_raw();
    test_simultaneous();
    test_stall_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
